// File: rtl/rgb565_frame_writer.sv
// Byte-serial RGB565 capture: packs hi/lo byte pairs into 16-bit words and writes
// exactly one raster-ordered frame into the frame RAM per arm request.
module rgb565_frame_writer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arm,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic [7:0]        pix_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_H);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  // Valid/ready: there is no backpressure. A byte is consumed on any edge where
  // href & pix_valid are high in ACTIVE; a write is a single-cycle wr_en pulse
  // that the RAM must accept unconditionally.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_ACTIVE  = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_d_q, href_d_q;
  logic              phase_q, phase_d;
  logic              full_q, full_d;
  logic [7:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              vs_fall, vs_rise, href_fall;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    full_d       = full_q;
    hi_d         = hi_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    vs_fall      = vsync_d_q & ~vsync;
    vs_rise      = ~vsync_d_q & vsync;
    href_fall    = href_d_q & ~href;

    unique case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          phase_d = 1'b0;
          full_d  = 1'b0;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          base_d  = '0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vs_rise) begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_VS;
        end else if (href_fall) begin
          phase_d = 1'b0;
          full_d  = 1'b0;
          if (col_q != '0) begin
            col_d = '0;
            // A short final line leaves no room in the frame: park row past the end.
            if (row_q == LAST_ROW) begin
              row_d = ROW_END;
            end else begin
              row_d  = row_q + 1'b1;
              addr_d = base_q + LINE_STEP;
              base_d = base_q + LINE_STEP;
            end
          end
        end else if (href && pix_valid) begin
          if (!phase_q) begin
            hi_d    = pix_byte;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!full_q && row_q != ROW_END) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {hi_q, pix_byte};
              if (col_q == LAST_COL) begin
                col_d  = '0;
                full_d = 1'b1;
                if (row_q == LAST_ROW) begin
                  state_d = S_FINISH;
                end else begin
                  row_d  = row_q + 1'b1;
                  addr_d = addr_q + 1'b1;
                  base_d = addr_q + 1'b1;
                end
              end else begin
                col_d  = col_q + 1'b1;
                addr_d = addr_q + 1'b1;
              end
            end
          end
        end
      end
      S_FINISH: begin
        // Final write is on the bus this cycle; signal completion right after it.
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      vsync_d_q    <= 1'b0;
      href_d_q     <= 1'b0;
      phase_q      <= 1'b0;
      full_q       <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_d_q    <= vsync;
      href_d_q     <= href;
      phase_q      <= phase_d;
      full_q       <= full_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rgb565_frame_writer.sv
// Bench for rgb565_frame_writer on a 4x2 frame: scoreboarded writes, framing
// pulses, short lines, aborts, unarmed streams and mid-frame reset.
module tb_rgb565_frame_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 20;
  localparam int SB_W   = ADDR_W + 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              arm, vsync, href, pix_valid;
  logic [7:0]        pix_byte;
  logic              wr_en, frame_done, frame_err, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        state_dbg;

  logic [SB_W-1:0]   exp_q[$];
  logic [SB_W-1:0]   exp_e;
  int                n_checks = 0;
  int                n_errs   = 0;
  int                done_seen = 0;
  int                err_seen  = 0;
  logic              prev_wr_en = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;

  rgb565_frame_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .vsync(vsync), .href(href),
    .pix_valid(pix_valid), .pix_byte(pix_byte), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_gap", 32'(prev_wr_en), 32'd0);
      if (exp_q.size() == 0) begin
        check("wr_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(exp_e[SB_W-1:16]));
        check("wr_data", 32'(wr_data), 32'(exp_e[15:0]));
      end
    end
    if (frame_done) begin
      done_seen++;
      check("done_prev_wr", 32'(prev_wr_en), 32'd1);
      check("done_prev_addr", 32'(prev_addr), 32'(IMG_W*IMG_H-1));
      check("done_busy", 32'(busy), 32'd0);
    end
    if (frame_err) err_seen++;
    prev_wr_en = wr_en;
    prev_addr  = wr_addr;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [15:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_byte  = b;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic send_line(input int row, input logic [7:0] first, input int nbytes,
                           input bit gaps, input bit exp_wr);
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      b = first + 8'(i);
      if (exp_wr && i[0]) push_exp(row*IMG_W + i/2, {b - 8'd1, b});
      send_byte(b, gaps);
    end
    href = 1'b0;
    tick();
    tick();
  endtask

  task automatic vs_fall();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic frame(input bit gaps, input bit exp_wr);
    vs_fall();
    send_line(0, 8'h00, 2*IMG_W, gaps, exp_wr);
    send_line(1, 8'h08, 2*IMG_W, gaps, exp_wr);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 100 && done_seen < n; i++) tick();
    check("done_cnt", 32'(done_seen), 32'(n));
    repeat (3) tick();
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; arm = 1'b0; vsync = 1'b1; href = 1'b0; pix_valid = 1'b0; pix_byte = '0;
    repeat (3) tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rstn = 1'b1;
    tick();

    // full frame
    do_arm();
    check("armed_busy", 32'(busy), 32'd1);
    frame(1'b0, 1'b1);
    wait_done(1);

    // gapped strobes
    do_arm();
    frame(1'b1, 1'b1);
    wait_done(2);

    // short line: 3 pixels + odd byte, addr 3 skipped
    do_arm();
    vs_fall();
    send_line(0, 8'h00, 7, 1'b0, 1'b1);
    send_line(1, 8'h10, 2*IMG_W, 1'b0, 1'b1);
    wait_done(3);

    // early vsync after 5 words, then automatic restart
    do_arm();
    vs_fall();
    send_line(0, 8'h20, 2*IMG_W, 1'b0, 1'b1);
    send_line(1, 8'h30, 2, 1'b0, 1'b1);
    vsync = 1'b1;
    repeat (3) tick();
    check("abort_err", 32'(err_seen), 32'd1);
    check("abort_no_done", 32'(done_seen), 32'd3);
    check("abort_busy", 32'(busy), 32'd1);
    frame(1'b0, 1'b1);
    wait_done(4);
    check("err_once", 32'(err_seen), 32'd1);

    // unarmed frame, then arm, then an ignored frame after completion
    frame(1'b0, 1'b0);
    check("unarmed_busy", 32'(busy), 32'd0);
    check("unarmed_done", 32'(done_seen), 32'd4);
    do_arm();
    frame(1'b1, 1'b1);
    wait_done(5);
    frame(1'b0, 1'b0);
    repeat (5) tick();
    check("post_done_cnt", 32'(done_seen), 32'd5);
    check("post_done_state", 32'(state_dbg), 32'd0);

    // arm together with vsync fall: capture waits for the next fall,
    // and a byte coincident with that fall is ignored
    vsync = 1'b1;
    repeat (3) tick();
    arm = 1'b1; vsync = 1'b0;
    tick();
    arm = 1'b0;
    send_line(0, 8'h40, 2*IMG_W, 1'b0, 1'b0);
    check("same_cycle_state", 32'(state_dbg), 32'd1);
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0; href = 1'b1; pix_valid = 1'b1; pix_byte = 8'hAA;
    tick();
    pix_valid = 1'b0;
    send_line(0, 8'h00, 2*IMG_W, 1'b0, 1'b1);
    send_line(1, 8'h08, 2*IMG_W, 1'b0, 1'b1);
    wait_done(6);

    // reset mid-frame after 3 words
    do_arm();
    vs_fall();
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) push_exp(i/2, {8'(i - 1), 8'(i)});
      send_byte(8'(i), 1'b0);
    end
    tick();
    tick();
    rstn = 1'b0;
    #2;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_data", 32'(wr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_q", 32'(exp_q.size()), 32'd0);
    tick();
    href = 1'b0;
    rstn = 1'b1;
    tick();
    frame(1'b0, 1'b0);
    repeat (5) tick();
    check("post_rst_done", 32'(done_seen), 32'd6);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
